// File: rtl/reg_file_sb_if.sv
// Bundle of register-file write, read and scoreboard signals.
// The issue/decode side drives through master; the register file sits on slave.
interface reg_file_sb_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int NREAD  = 2
);
  logic                     we;
  logic [AWIDTH-1:0]        waddr;
  logic [DWIDTH-1:0]        wdata;
  logic [NREAD*AWIDTH-1:0]  raddr;
  logic [NREAD*DWIDTH-1:0]  rdata;
  logic [NREAD-1:0]         rbusy;
  logic                     sb_set;
  logic [AWIDTH-1:0]        sb_addr;
  logic                     flush;
  logic [AWIDTH:0]          busy_cnt;

  modport master (
    output we, waddr, wdata, raddr, sb_set, sb_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  we, waddr, wdata, raddr, sb_set, sb_addr, flush,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, write bypass, optional
// hardwired zero register and a per-register busy scoreboard with live count.
module reg_file_sb #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [AWIDTH:0]   busy_cnt_q, busy_cnt_d;
  logic              wr_en;
  logic [AWIDTH-1:0] rd_addr [NREAD];
  logic [NREAD-1:0]  rd_byp;

  function automatic logic is_zero(input logic [AWIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr_en = bus.we && !is_zero(bus.waddr);

  // Set outranks flush, which outranks the completing write's clear.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (bus.sb_set && (bus.sb_addr == AWIDTH'(r)) && !is_zero(bus.sb_addr))
        busy_d[r] = 1'b1;
      else if (bus.flush)
        busy_d[r] = 1'b0;
      else if (bus.we && (bus.waddr == AWIDTH'(r)))
        busy_d[r] = 1'b0;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < DEPTH; r++)
      busy_cnt_d = busy_cnt_d + {{AWIDTH{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_en) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  // Outputs are forced to zero while reset is held so a pending write
  // cannot leak through the bypass path.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    rd_byp    = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr[i] = bus.raddr[i*AWIDTH +: AWIDTH];
      rd_byp[i]  = wr_en && (bus.waddr == rd_addr[i]);
      if (!rst && !is_zero(rd_addr[i])) begin
        bus.rdata[i*DWIDTH +: DWIDTH] = rd_byp[i] ? bus.wdata : mem_q[rd_addr[i]];
        bus.rbusy[i]                  = !rd_byp[i] && busy_q[rd_addr[i]];
      end
    end
  end

  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed check of reg_file_sb against an array-based model.
module tb_reg_file_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_file_sb_if #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR)) bus ();

  reg_file_sb #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Rules applied lowest priority first so later ones win.
  task automatic model_update();
    if (rst) return;
    if (bus.we && bus.waddr != 0) m_mem[bus.waddr] = bus.wdata;
    if (bus.we) m_busy[bus.waddr] = 1'b0;
    if (bus.flush) for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
    if (bus.sb_set && bus.sb_addr != 0) m_busy[bus.sb_addr] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_rdata(input int a);
    if (rst || a == 0) return '0;
    if (bus.we && int'(bus.waddr) == a) return bus.wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_rbusy(input int a);
    if (rst || a == 0) return 1'b0;
    if (bus.we && int'(bus.waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    if (rst) return 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic int ra(input int i);
    logic [NR*AW-1:0] v;
    v = bus.raddr;
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] rd(input int i);
    logic [NR*DW-1:0] v;
    v = bus.rdata;
    return v[i*DW +: DW];
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("model_rdata%0d", i), 64'(rd(i)), 64'(exp_rdata(ra(i))));
      chk($sformatf("model_rbusy%0d", i), 64'(bus.rbusy[i]), 64'(exp_rbusy(ra(i))));
    end
    chk("model_busy_cnt", 64'(bus.busy_cnt), 64'(exp_cnt()));
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.flush = 1'b0;
  endtask

  task automatic set_raddr(input int a0, input int a1, input int a2, input int a3);
    bus.raddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    set_raddr(0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("reset_rbusy", 64'(bus.rbusy), 64'd0);
    rst = 1'b0;
    edge_step();

    // Write then read via bypass and array
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h12345678;
    set_raddr(3, 4, 0, 0);
    settle();
    chk("bypass_rdata0", 64'(rd(0)), 64'h12345678);
    chk("unwritten_rdata1", 64'(rd(1)), 64'h0);
    edge_step();
    idle();
    settle();
    chk("array_rdata0", 64'(rd(0)), 64'h12345678);

    // Zero register
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
    set_raddr(0, 0, 0, 0);
    settle();
    chk("zero_rdata_same", 64'(rd(0)), 64'h0);
    chk("zero_rbusy_same", 64'(bus.rbusy[0]), 64'h0);
    edge_step();
    idle();
    settle();
    chk("zero_rdata_next", 64'(rd(0)), 64'h0);
    chk("zero_rbusy_next", 64'(bus.rbusy[0]), 64'h0);
    chk("zero_busy_cnt", 64'(bus.busy_cnt), 64'd0);

    // Scoreboard set then clear
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
    settle();
    edge_step();
    idle();
    set_raddr(7, 0, 0, 0);
    settle();
    chk("sb_set_rbusy", 64'(bus.rbusy[0]), 64'h1);
    chk("sb_set_cnt", 64'(bus.busy_cnt), 64'd1);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hA5;
    settle();
    chk("wclr_rbusy_same", 64'(bus.rbusy[0]), 64'h0);
    chk("wclr_rdata_same", 64'(rd(0)), 64'hA5);
    edge_step();
    idle();
    settle();
    chk("wclr_cnt_next", 64'(bus.busy_cnt), 64'd0);
    chk("wclr_rbusy_next", 64'(bus.rbusy[0]), 64'h0);

    // Simultaneous set, write and flush
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    settle();
    edge_step();
    bus.sb_addr = 5'd10;
    settle();
    edge_step();
    idle();
    settle();
    chk("two_busy_cnt", 64'(bus.busy_cnt), 64'd2);
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
    bus.flush = 1'b1;
    settle();
    edge_step();
    idle();
    set_raddr(9, 10, 0, 0);
    settle();
    chk("simul_rbusy9", 64'(bus.rbusy[0]), 64'h1);
    chk("simul_rbusy10", 64'(bus.rbusy[1]), 64'h0);
    chk("simul_cnt", 64'(bus.busy_cnt), 64'd1);
    chk("simul_mem9", 64'(rd(0)), 64'h99);
    bus.flush = 1'b1;
    settle();
    edge_step();
    idle();

    // Port aliasing
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'h55;
    settle();
    edge_step();
    idle();
    set_raddr(12, 12, 12, 12);
    settle();
    for (int i = 0; i < NR; i++) chk($sformatf("alias_array%0d", i), 64'(rd(i)), 64'h55);
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'h66;
    settle();
    for (int i = 0; i < NR; i++) chk($sformatf("alias_bypass%0d", i), 64'(rd(i)), 64'h66);
    edge_step();
    idle();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      bus.we      = ($urandom_range(0, 1) == 1);
      bus.waddr   = AW'($urandom_range(0, 15));
      bus.wdata   = $urandom();
      bus.sb_set  = ($urandom_range(0, 2) == 0);
      bus.sb_addr = AW'($urandom_range(0, 15));
      bus.flush   = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) == 0) bus.raddr[i*AW +: AW] = bus.waddr;
        else bus.raddr[i*AW +: AW] = AW'($urandom_range(0, 15));
      end
      settle();
      edge_step();
    end
    idle();

    // Asynchronous reset mid-stream
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd5;
    settle();
    edge_step();
    idle();
    set_raddr(5, 5, 0, 0);
    settle();
    chk("pre_rst_rdata", 64'(rd(0)), 64'hDEADBEEF);
    chk("pre_rst_rbusy", 64'(bus.rbusy[0]), 64'h1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_rdata", 64'(rd(0)), 64'h0);
    chk("rst_rbusy", 64'(bus.rbusy[0]), 64'h0);
    chk("rst_cnt", 64'(bus.busy_cnt), 64'd0);
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1;
    settle();
    chk("rst_bypass_blocked", 64'(rd(0)), 64'h0);
    edge_step();
    idle();
    settle();
    rst = 1'b0;
    #1;
    bus.we = 1'b1; bus.waddr = 5'd6; bus.wdata = 32'h77;
    set_raddr(6, 5, 0, 0);
    settle();
    edge_step();
    idle();
    settle();
    chk("post_rst_write", 64'(rd(0)), 64'h77);
    chk("post_rst_cleared", 64'(rd(1)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with N combinational read ports, one write port, same-cycle write-to-read bypass, a hardwired zero register and a per-register busy scoreboard. It replaces the two-read-port, no-reset register file in the decode stage. The scoreboard lets the issue logic stall on registers that still await a pending producer, such as an outstanding load, without a separate hazard unit.

## Interface
- AWIDTH, 5, register address width; depth is 2**AWIDTH.
- DWIDTH, 32, data width.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as zero, is never written and is never busy.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- we  input  1  write enable.
- waddr  input  AWIDTH  write address.
- wdata  input  DWIDTH  write data.
- raddr  input  NREAD*AWIDTH  read addresses; port i occupies bits [i*AWIDTH +: AWIDTH].
- rdata  output  NREAD*DWIDTH  read data; port i occupies bits [i*DWIDTH +: DWIDTH].
- rbusy  output  NREAD  bit i set means the register on port i awaits a pending write.
- sb_set  input  1  marks sb_addr busy (a producer was issued).
- sb_addr  input  AWIDTH  register to mark busy.
- flush  input  1  clears all busy bits (pipeline flush).
- busy_cnt  output  AWIDTH+1  number of registers currently busy.

## Operation
- **Storage:** array of 2**AWIDTH words by DWIDTH bits, plus a busy vector of 2**AWIDTH bits.
- **Reset (rst=1, asynchronous):**
  - All words cleared to 0.
  - All busy bits cleared.
  - busy_cnt = 0.
  - Reset overrides every other input, including when asserted mid-operation.
  - Because reads are combinational, rdata reads 0 and rbusy reads 0 while rst is held.
- **Write:** when we=1, mem[waddr] <= wdata at the rising edge.
  - With ZERO_REG=1, writes to address 0 are discarded.
- **Read port i:** combinational from raddr.
  - Bypass: if we=1, waddr==raddr_i and the address is not the zero register, rdata_i = wdata. Otherwise rdata_i = mem[raddr_i].
  - With ZERO_REG=1, raddr_i==0 gives rdata_i = 0 regardless of we or wdata.
- **rbusy_i:**
  - Equals busy[raddr_i], except it is 0 when the bypass condition for port i holds (the value is arriving this cycle).
  - With ZERO_REG=1, it is 0 for address 0.
- **Scoreboard next-state, per register r, in priority order:**
  1. sb_set=1 and sb_addr==r: busy <= 1.
  2. else flush=1: busy <= 0.
  3. else we=1 and waddr==r: busy <= 0.
  4. else hold.
  - Set beats flush and beats the same-cycle write clear: a new producer was issued after the completing one.
  - With ZERO_REG=1, sb_set to address 0 is ignored.
  - Writing a register that is not busy is legal and leaves busy=0.
- **busy_cnt:** registered population count of the busy vector. It always equals the number of set busy bits after the edge, computed from the next-state vector so it is never stale.
- Independent read ports may alias the same address. Each returns identical data.

## Timing
- Write-to-read latency:
  - Through bypass: 0 cycles, visible the same cycle.
  - From the array: visible from the cycle after the edge.
- Read latency: combinational, no clock.
- The sb_set effect appears on rbusy and busy_cnt the cycle after the edge.
- A write clear takes effect on the array at the edge. rbusy drops in the same cycle through bypass, then stays 0 from the array.
- flush takes effect at the edge. Registers set in the same cycle remain busy, so busy_cnt = 1 after flush plus set.
- Deasserting rst gives normal operation from the first following rising edge. There is no warm-up.

## Test plan
- **Reset:** drive rst=1 mid-stream after writing mem[5]=0xDEADBEEF and setting busy[5] -> rdata for raddr=5 is 0, rbusy=0, busy_cnt=0 immediately, without waiting for a clock edge.
- **Write then read:**
  - we=1, waddr=3, wdata=0x12345678, raddr0=3 -> rdata0=0x12345678 in the same cycle (bypass) and in the next cycle with we=0.
  - raddr1=4 in the same cycle -> 0.
- **Zero register:** we=1, waddr=0, wdata=0xFFFFFFFF and sb_set=1, sb_addr=0 -> rdata for raddr=0 is 0 in the same and next cycle, rbusy=0, busy_cnt unchanged.
- **Scoreboard set then clear:**
  - sb_set to address 7 -> next cycle rbusy=1 for raddr=7, busy_cnt=1.
  - Then we=1, waddr=7, wdata=0xA5 -> rbusy=0 and rdata=0xA5 in the same cycle; next cycle busy_cnt=0.
- **Simultaneous events:**
  - busy[9] and busy[10] set, then in one cycle sb_set to 9, we to 9 and flush=1 -> after the edge busy[9]=1, busy[10]=0, busy_cnt=1, mem[9] holds the written data.
- **Port aliasing:** with NREAD=4, all raddr=12 and mem[12]=0x55 -> all four rdata equal 0x55; a bypass write of 0x66 to 12 makes all four read 0x66 in the same cycle.
